// File: rtl/hdlc_destuff.sv
// HDLC byte-stream destuffer: strips flags, undoes control-escape, and delivers
// framed bytes with one byte of lookahead so the last byte can carry eop/error flags.
module hdlc_destuff #(
  parameter int unsigned MAX_LEN = 1500,
  parameter logic [7:0]  FLAG    = 8'h7E,
  parameter logic [7:0]  ESC     = 8'h7D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [7:0]  data_des,
  output logic        valid_des,
  output logic        sop_des,
  output logic        eop_des,
  output logic        abort_err,
  output logic        len_err,
  output logic [15:0] frame_len
);

  typedef enum logic [1:0] {HUNT, OPEN, DATA, ESCD} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hold_reg;
  logic        have_reg;
  logic        first_reg;
  logic [15:0] count_reg;

  logic        emit, emit_eop, emit_abort, load, drop;
  logic [7:0]  load_byte;

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_abort = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    load_byte  = data_in;
    if (valid_in) begin
      case (state_reg)
        HUNT: begin
          if (data_in == FLAG) state_next = OPEN;
        end
        OPEN: begin
          if (data_in == ESC) begin
            state_next = ESCD;
          end else if (data_in != FLAG) begin
            load       = 1'b1;
            state_next = DATA;
          end
        end
        DATA: begin
          if (data_in == FLAG) begin
            emit       = 1'b1;
            emit_eop   = 1'b1;
            drop       = 1'b1;
            state_next = OPEN;
          end else if (data_in == ESC) begin
            state_next = ESCD;
          end else begin
            emit = 1'b1;
            load = 1'b1;
          end
        end
        ESCD: begin
          if (data_in == FLAG || data_in == ESC) begin
            // Abort: flush whatever is held as a terminated frame.
            emit       = have_reg;
            emit_eop   = have_reg;
            emit_abort = have_reg;
            drop       = 1'b1;
            state_next = (data_in == FLAG) ? OPEN : HUNT;
          end else begin
            load_byte  = data_in ^ 8'h20;
            emit       = have_reg;
            load       = 1'b1;
            state_next = DATA;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= HUNT;
      hold_reg  <= 8'h00;
      have_reg  <= 1'b0;
      first_reg <= 1'b0;
      count_reg <= 16'd0;
      data_des  <= 8'h7E;
      valid_des <= 1'b0;
      sop_des   <= 1'b0;
      eop_des   <= 1'b0;
      abort_err <= 1'b0;
      len_err   <= 1'b0;
      frame_len <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        hold_reg  <= load_byte;
        have_reg  <= 1'b1;
        // A load into an empty hold register starts a new frame.
        first_reg <= !have_reg;
        if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
      end else if (drop) begin
        have_reg  <= 1'b0;
        first_reg <= 1'b0;
        count_reg <= 16'd0;
      end
      valid_des <= emit;
      data_des  <= emit ? hold_reg : 8'h7E;
      sop_des   <= emit & first_reg;
      eop_des   <= emit & emit_eop;
      abort_err <= emit & emit_abort;
      len_err   <= emit & emit_eop & (32'(count_reg) > 32'(MAX_LEN));
      if (emit && emit_eop) frame_len <= count_reg;
    end
  end

endmodule

// File: tb/tb_hdlc_destuff.sv
// Directed table-driven bench for hdlc_destuff (instantiated with MAX_LEN=4).
module tb_hdlc_destuff;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  data_des;
  logic        valid_des, sop_des, eop_des, abort_err, len_err;
  logic [15:0] frame_len;

  always #5 clk = ~clk;

  hdlc_destuff #(.MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_des(data_des), .valid_des(valid_des), .sop_des(sop_des),
    .eop_des(eop_des), .abort_err(abort_err), .len_err(len_err),
    .frame_len(frame_len)
  );

  typedef struct {
    logic        rst;
    logic        vin;
    logic [7:0]  din;
    logic        ev;
    logic [7:0]  ed;
    logic        es, ee, ea, el;
    logic [15:0] efl;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic done = 1'b0;

  // Input byte with no output expected.
  function automatic void n(input logic [7:0] d, input logic [15:0] fl);
    vecs.push_back('{1'b1, 1'b1, d, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, fl});
  endfunction

  // Input byte that releases held byte e.
  function automatic void o(input logic [7:0] d, input logic [7:0] e, input logic s,
                            input logic eo, input logic a, input logic l,
                            input logic [15:0] fl);
    vecs.push_back('{1'b1, 1'b1, d, 1'b1, e, s, eo, a, l, fl});
  endfunction

  function automatic void gap(input logic [15:0] fl);
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, fl});
  endfunction

  function automatic void rst_cyc();
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
  endfunction

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: bench did not complete within the wait limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    // reset state
    rst_cyc(); rst_cyc();
    // 7E 01 02 03 7E
    n(8'h7E, 0); n(8'h01, 0);
    o(8'h02, 8'h01, 1, 0, 0, 0, 0);
    o(8'h03, 8'h02, 0, 0, 0, 0, 0);
    o(8'h7E, 8'h03, 0, 1, 0, 0, 3);
    // 7E 7D 5E 7D 5D 7E
    n(8'h7E, 3); n(8'h7D, 3); n(8'h5E, 3); n(8'h7D, 3);
    o(8'h5D, 8'h7E, 1, 0, 0, 0, 3);
    o(8'h7E, 8'h7D, 0, 1, 0, 0, 2);
    // shared flag, then empty frames
    n(8'h7E, 2); n(8'hAA, 2);
    o(8'h7E, 8'hAA, 1, 1, 0, 0, 1);
    n(8'hBB, 1);
    o(8'h7E, 8'hBB, 1, 1, 0, 0, 1);
    n(8'h7E, 1); n(8'h7E, 1); n(8'h7E, 1);
    // abort by ESC FLAG, then next frame
    n(8'h11, 1);
    o(8'h22, 8'h11, 1, 0, 0, 0, 1);
    n(8'h7D, 1);
    o(8'h7E, 8'h22, 0, 1, 1, 0, 2);
    n(8'h33, 2);
    o(8'h7E, 8'h33, 1, 1, 0, 0, 1);
    // 5-byte frame exceeds MAX_LEN=4
    n(8'h01, 1);
    o(8'h02, 8'h01, 1, 0, 0, 0, 1);
    o(8'h03, 8'h02, 0, 0, 0, 0, 1);
    o(8'h04, 8'h03, 0, 0, 0, 0, 1);
    o(8'h05, 8'h04, 0, 0, 0, 0, 1);
    o(8'h7E, 8'h05, 0, 1, 0, 1, 5);
    // 4-byte frame is legal
    n(8'hA1, 5);
    o(8'hA2, 8'hA1, 1, 0, 0, 0, 5);
    o(8'hA3, 8'hA2, 0, 0, 0, 0, 5);
    o(8'hA4, 8'hA3, 0, 0, 0, 0, 5);
    o(8'h7E, 8'hA4, 0, 1, 0, 0, 4);
    // ESC ESC aborts into HUNT; bytes before a new flag are discarded
    n(8'h41, 4); n(8'h7D, 4);
    o(8'h7D, 8'h41, 1, 1, 1, 0, 1);
    n(8'h42, 1); n(8'h7E, 1); n(8'h43, 1);
    o(8'h7E, 8'h43, 1, 1, 0, 0, 1);
    // abort with nothing held gives no output
    n(8'h7D, 1); n(8'h7E, 1);
    // escape split by a valid_in gap
    n(8'h7D, 1); gap(1); n(8'h31, 1); gap(1);
    o(8'h7E, 8'h11, 1, 1, 0, 0, 1);
    // mid-frame reset, then 7E 05 7E with gaps
    n(8'h01, 1);
    o(8'h02, 8'h01, 1, 0, 0, 0, 1);
    rst_cyc();
    n(8'h09, 0); n(8'h7E, 0); gap(0); n(8'h05, 0); gap(0); gap(0);
    o(8'h7E, 8'h05, 1, 1, 0, 0, 1);
    gap(1);

    rst = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      valid_in = vecs[i].vin;
      data_in  = vecs[i].din;
      @(posedge clk);
      #1;
      checks++;
      if ({valid_des, data_des, sop_des, eop_des, abort_err, len_err, frame_len} !==
          {vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ee, vecs[i].ea, vecs[i].el, vecs[i].efl}) begin
        errors++;
        $display("FAIL vec%0d in=%h/%b: got v=%b d=%h s=%b e=%b a=%b l=%b fl=%0d, want v=%b d=%h s=%b e=%b a=%b l=%b fl=%0d",
                 i, vecs[i].din, vecs[i].vin, valid_des, data_des, sop_des, eop_des,
                 abort_err, len_err, frame_len, vecs[i].ev, vecs[i].ed, vecs[i].es,
                 vecs[i].ee, vecs[i].ea, vecs[i].el, vecs[i].efl);
      end else begin
        $display("vec%0d rst=%b vin=%b din=%h -> v=%b d=%h s=%b e=%b a=%b l=%b fl=%0d ok",
                 i, vecs[i].rst, vecs[i].vin, vecs[i].din, valid_des, data_des,
                 sop_des, eop_des, abort_err, len_err, frame_len);
      end
    end

    // reset held with valid input present: outputs must stay at reset values
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b1;
      data_in  = (k == 0) ? 8'h7E : 8'h55;
      @(posedge clk);
      #1;
      if (k > 0) begin
        checks++;
        if (valid_des !== 1'b0 || data_des !== 8'h7E || sop_des !== 1'b0 ||
            eop_des !== 1'b0 || abort_err !== 1'b0 || len_err !== 1'b0 ||
            frame_len !== 16'd0) begin
          errors++;
          $display("FAIL reset%0d: got v=%b d=%h s=%b e=%b a=%b l=%b fl=%0d, want reset values",
                   k, valid_des, data_des, sop_des, eop_des, abort_err, len_err, frame_len);
        end else begin
          $display("reset%0d rst=0 vin=1 din=%h -> v=%b d=%h s=%b e=%b a=%b l=%b fl=%0d ok",
                   k, data_in, valid_des, data_des, sop_des, eop_des, abort_err,
                   len_err, frame_len);
        end
      end
    end

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
